// File: rtl/alu_sequencer.sv
// Hardwired fetch + three-operand ALU control sequencer for the single-bus Datapath.
// Optional single-step mode is enabled by defining SEQ_STEP_EN (adds the step port).
module alu_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] ir,
`ifdef SEQ_STEP_EN
   input  logic        step,
`endif
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic [4:0]  opcode,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] MUL_OP = 5'b01111;
   localparam logic [4:0] DIV_OP = 5'b10000;
   localparam logic [4:0] NOP_OP = 5'b11010;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T0   = 3'd1,
      T1   = 3'd2,
      T2   = 3'd3,
      T3   = 3'd4,
      T4   = 3'd5,
      T5   = 3'd6,
      T6   = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] irOp;
   logic [3:0] irRa, irRb, irRc;
   logic       isNop, isLong, isFinal, advance;
   logic       unusedIrBits;

   assign irOp         = ir[31:27];
   assign irRa         = ir[26:23];
   assign irRb         = ir[22:19];
   assign irRc         = ir[18:15];
   assign unusedIrBits = ^ir[14:0];
   assign isNop        = (irOp == NOP_OP);
   assign isLong       = (irOp == MUL_OP) || (irOp == DIV_OP);

`ifdef SEQ_STEP_EN
   assign advance = step;
`else
   assign advance = 1'b1;
`endif

   function automatic logic [15:0] oneHot(input logic [3:0] idx);
      oneHot = 16'h0001 << idx;
   endfunction

   // The final state depends on the freshly loaded IR, so it is decoded from ir rather than stored.
   assign isFinal = ((state_q == T3) && isNop) ||
                    ((state_q == T5) && !isLong) ||
                    (state_q == T6);

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (start) state_d = T0;
      end else if (advance) begin
         if (isFinal) begin
            state_d = start ? T0 : IDLE;
         end else begin
            case (state_q)
               T0:      state_d = T1;
               T1:      state_d = T2;
               T2:      state_d = T3;
               T3:      state_d = T4;
               T4:      state_d = T5;
               T5:      state_d = T6;
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Outputs are a pure decode of state and ir so that clear silences them without a clock edge.
   always_comb begin
      PCout    = 1'b0;
      MARin    = 1'b0;
      IncPC    = 1'b0;
      PCin     = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Rout     = 16'h0000;
      Rin      = 16'h0000;
      opcode   = NOP_OP;
      busy     = (state_q != IDLE);
      done     = isFinal;
      case (state_q)
         T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         T3: begin
            if (!isNop) begin
               Rout = oneHot(irRb);
               Yin  = 1'b1;
            end
         end
         T4: begin
            Rout   = oneHot(irRc);
            opcode = irOp;
            Zin    = 1'b1;
         end
         T5: begin
            Zlowout = 1'b1;
            if (isLong) LOin = 1'b1;
            else        Rin  = oneHot(irRa);
         end
         T6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
